// File: rtl/rv32_pkg.sv
// RV32I decode definitions shared by the decode stage and later pipeline stages.
// Holds opcode constants, instruction format encodings and the decoded-bundle struct.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  localparam logic [6:0] OP_R      = 7'h33;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_SB  = 3'd3,
    FMT_U   = 3'd4,
    FMT_UJ  = 3'd5,
    FMT_ILL = 3'd6
  } fmt_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    fmt_t            fmt;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
  } dec_t;

  function automatic fmt_t fmt_of(input logic [6:0] op);
    case (op)
      OP_R:                     return FMT_R;
      OP_LOAD, OP_IMM, OP_JALR: return FMT_I;
      OP_STORE:                 return FMT_S;
      OP_BRANCH:                return FMT_SB;
      OP_LUI, OP_AUIPC:         return FMT_U;
      OP_JAL:                   return FMT_UJ;
      default:                  return FMT_ILL;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode_stage_imm_gen.sv
// Immediate generator: sign-extended RV32I immediate from raw word and format.
// Purely combinational, no handshake; R and illegal formats yield zero.
module imm_gen
  import rv32_pkg::*;
(
  input  logic [31:0] instr,
  input  fmt_t        fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_SB:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      FMT_UJ:  imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// RV32I decode stage with 2-entry skid buffer; 1-cycle latency, full throughput.
// in_ready is a registered function of occupancy only; it drops while both entries hold data.
module instr_decode_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = rv32_pkg::XLEN,
  parameter int CNT_W = rv32_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [2:0]       out_fmt,
  output logic [6:0]       out_opcode,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] dec_count,
  output logic [CNT_W-1:0] ill_count
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t      state;
  dec_t        dec_in;
  dec_t        main_q;
  dec_t        skid_q;
  fmt_t        in_fmt;
  logic [31:0] in_imm;
  logic        accept;
  logic        drain;

  assign in_fmt = fmt_of(in_instr[6:0]);

  imm_gen u_imm_gen (
    .instr (in_instr),
    .fmt   (in_fmt),
    .imm   (in_imm)
  );

  always_comb begin
    dec_in        = '0;
    dec_in.pc     = in_pc;
    dec_in.fmt    = in_fmt;
    dec_in.opcode = in_instr[6:0];
    dec_in.rd     = in_instr[11:7];
    dec_in.rs1    = in_instr[19:15];
    dec_in.rs2    = in_instr[24:20];
    dec_in.funct3 = in_instr[14:12];
    dec_in.funct7 = in_instr[31:25];
    dec_in.imm    = in_imm;
  end

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      dec_count <= '0;
      ill_count <= '0;
    end else if (flush) begin
      // Offered word and any drain this cycle are both ignored.
      state     <= ST_EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      if (drain) begin
        dec_count <= dec_count + 1'b1;
        if (main_q.fmt == FMT_ILL)
          ill_count <= ill_count + 1'b1;
      end
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_q    <= dec_in;
            state     <= ST_ONE;
            out_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_q <= dec_in;
          end else if (accept) begin
            skid_q   <= dec_in;
            state    <= ST_FULL;
            in_ready <= 1'b0;
          end else if (drain) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (drain) begin
            main_q   <= skid_q;
            state    <= ST_ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_pc     = main_q.pc;
  assign out_fmt    = main_q.fmt;
  assign out_opcode = main_q.opcode;
  assign out_rd     = main_q.rd;
  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_funct3 = main_q.funct3;
  assign out_funct7 = main_q.funct7;
  assign out_imm    = main_q.imm;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_instr_decode_stage;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [2:0]  out_fmt;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic [15:0] dec_count, ill_count;

  instr_decode_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_fmt(out_fmt),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .dec_count(dec_count), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } exp_t;

  // Reference decode written arithmetically from the ISA immediate layouts.
  function automatic exp_t ref_decode(input logic [31:0] pc, input logic [31:0] w);
    exp_t e;
    int   s;
    int   top;
    s   = int'($signed(w));
    top = s >>> 31;
    e.pc = pc; e.opcode = w[6:0]; e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20];
    e.funct3 = w[14:12]; e.funct7 = w[31:25];
    case (w[6:0])
      7'h33:               begin e.fmt = FMT_R;  e.imm = 0; end
      7'h03, 7'h13, 7'h67: begin e.fmt = FMT_I;  e.imm = s >>> 20; end
      7'h23: begin e.fmt = FMT_S;  e.imm = (s >>> 25) * 32 + int'(w[11:7]); end
      7'h63: begin e.fmt = FMT_SB;
        e.imm = top * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2; end
      7'h37, 7'h17:        begin e.fmt = FMT_U;  e.imm = w & 32'hFFFFF000; end
      7'h6F: begin e.fmt = FMT_UJ;
        e.imm = top * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2; end
      default:             begin e.fmt = FMT_ILL; e.imm = 0; end
    endcase
    return e;
  endfunction

  exp_t        q[$];
  logic [15:0] m_dec = 0, m_ill = 0;
  int          cyc = 0;
  logic [31:0] log_pc[$], log_imm[$];
  logic [2:0]  log_fmt[$];
  int          log_cyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dec = 0;
      m_ill = 0;
    end else begin
      int sz;
      bit acc, drn;
      cyc++;
      sz  = q.size();
      acc = in_valid && (sz < 2);
      drn = (sz > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (drn) begin
          m_dec++;
          if (q[0].fmt == FMT_ILL) m_ill++;
          log_pc.push_back(q[0].pc); log_imm.push_back(q[0].imm);
          log_fmt.push_back(q[0].fmt); log_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        if (acc) q.push_back(ref_decode(in_pc, in_instr));
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("dec_count", 32'(dec_count), 32'(m_dec));
      chk("ill_count", 32'(ill_count), 32'(m_ill));
      if (q.size() > 0) begin
        chk("pc", out_pc, q[0].pc);
        chk("fmt", 32'(out_fmt), 32'(q[0].fmt));
        chk("opcode", 32'(out_opcode), 32'(q[0].opcode));
        chk("rd", 32'(out_rd), 32'(q[0].rd));
        chk("rs1", 32'(out_rs1), 32'(q[0].rs1));
        chk("rs2", 32'(out_rs2), 32'(q[0].rs2));
        chk("funct3", 32'(out_funct3), 32'(q[0].funct3));
        chk("funct7", 32'(out_funct7), 32'(q[0].funct7));
        chk("imm", out_imm, q[0].imm);
      end
    end
  end

  // Present one word and return at the negedge after the edge that accepted it.
  task automatic send(input logic [31:0] pc, input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1; in_pc = pc; in_instr = w;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (n == 50) begin tests++; failed++; $display("FAIL send_timeout: in_ready stuck 0, pc 0x%08h", pc); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int base;
    int found;
    logic [15:0] d0;

    // Reset values
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_dec_count", 32'(dec_count), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // add x3,x1,x2
    send(32'h28, 32'h002081B3);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_pc", out_pc, 32'h28);
    chk("add_fmt", 32'(out_fmt), 32'(FMT_R));
    chk("add_funct7", 32'(out_funct7), 32'h0);
    chk("add_rs2", 32'(out_rs2), 32'h2);
    chk("add_rs1", 32'(out_rs1), 32'h1);
    chk("add_funct3", 32'(out_funct3), 32'h0);
    chk("add_rd", 32'(out_rd), 32'h3);
    chk("add_opcode", 32'(out_opcode), 32'h33);
    chk("add_imm", out_imm, 32'h0);
    @(negedge clk);

    // Streaming immediates
    base = log_pc.size();
    send(32'h100, 32'hFFC12283);
    send(32'h104, 32'h00612423);
    send(32'h108, 32'hFE208CE3);
    send(32'h10C, 32'h010000EF);
    repeat (3) @(negedge clk);
    chk("stream_len", 32'(log_pc.size() - base), 32'd4);
    if (log_pc.size() - base == 4) begin
      chk("stream_imm0", log_imm[base],   32'hFFFFFFFC);
      chk("stream_imm1", log_imm[base+1], 32'h00000008);
      chk("stream_imm2", log_imm[base+2], 32'hFFFFFFF8);
      chk("stream_imm3", log_imm[base+3], 32'h00000010);
      chk("stream_gap", 32'(log_cyc[base+3] - log_cyc[base]), 32'd3);
    end
    chk("stream_dec_count", 32'(dec_count), 32'd5);

    // Backpressure: two accepted, third held off until release
    out_ready = 1'b0;
    base = log_pc.size();
    send(32'h200, 32'h002081B3);
    send(32'h204, 32'h00612423);
    chk("bp_in_ready_full", 32'(in_ready), 32'h0);
    in_valid = 1'b1; in_pc = 32'h208; in_instr = 32'hFFC12283;
    repeat (3) @(negedge clk);
    chk("bp_hold_pc", out_pc, 32'h200);
    chk("bp_hold_rd", 32'(out_rd), 32'h3);
    chk("bp_hold_in_ready", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    send(32'h208, 32'hFFC12283);
    repeat (3) @(negedge clk);
    chk("bp_len", 32'(log_pc.size() - base), 32'd3);
    if (log_pc.size() - base == 3) begin
      chk("bp_order0", log_pc[base],   32'h200);
      chk("bp_order1", log_pc[base+1], 32'h204);
      chk("bp_order2", log_pc[base+2], 32'h208);
      chk("bp_gap", 32'(log_cyc[base+2] - log_cyc[base]), 32'd2);
    end

    // Illegal opcode
    send(32'h400, 32'hFFFFFFFF);
    chk("ill_fmt", 32'(out_fmt), 32'(FMT_ILL));
    chk("ill_imm", out_imm, 32'h0);
    repeat (2) @(negedge clk);
    chk("ill_count", 32'(ill_count), 32'h1);
    chk("ill_log_fmt", 32'(log_fmt[log_fmt.size()-1]), 32'(FMT_ILL));

    // Flush while FULL, with a word offered and a drain requested
    out_ready = 1'b0;
    send(32'h300, 32'h00000013);
    send(32'h304, 32'h00000013);
    d0 = m_dec;
    base = log_pc.size();
    in_valid = 1'b1; in_pc = 32'hDEAD0; in_instr = 32'h00000013;
    flush = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    chk("flush_dec_count", 32'(dec_count), 32'(d0));
    repeat (3) @(negedge clk);
    found = 0;
    for (int i = base; i < log_pc.size(); i++) if (log_pc[i] == 32'hDEAD0) found++;
    chk("flush_dropped", 32'(found), 32'h0);
    chk("flush_no_drain", 32'(log_pc.size() - base), 32'h0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    send(32'h500, 32'h00000013);
    send(32'h504, 32'h00000013);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h1);
    chk("arst_dec_count", 32'(dec_count), 32'h0);
    chk("arst_ill_count", 32'(ill_count), 32'h0);
    chk("arst_out_pc", out_pc, 32'h0);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    send(32'h600, 32'h12345037);
    chk("post_rst_imm", out_imm, 32'h12345000);
    repeat (2) @(negedge clk);
    chk("post_rst_dec_count", 32'(dec_count), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
